// File: rtl/onn_pkg.sv
// Shared ONN constants and the phase-oscillator controller state encoding.
package onn_pkg;

    localparam int ONN_N_OSC  = 15;
    localparam int ONN_PW     = 4;
    localparam int ONN_PERIOD = 1 << ONN_PW;
    localparam int ONN_HALF   = ONN_PERIOD / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } onn_state_e;

endpackage

// File: rtl/onn_osc_cell.sv
// One oscillator: active phase register plus the half-period comparator.
module onn_osc_cell
    import onn_pkg::*;
#(
    parameter int PW = ONN_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          apply_i,
    input  logic [PW-1:0] phase_i,
    input  logic [PW-1:0] phase_cnt_i,
    input  logic          en_i,
    output logic          osc_o
);

    localparam logic [PW-1:0] HALF = PW'(1 << (PW - 1));

    logic [PW-1:0] active_q;
    logic [PW-1:0] diff;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= '0;
        end else if (apply_i) begin
            active_q <= phase_i;
        end
    end

    // Unsigned PW-bit subtraction wraps modulo the period by construction.
    assign diff  = phase_cnt_i - active_q;
    assign osc_o = en_i && (diff < HALF);

endmodule

// File: rtl/phase_osc_array.sv
// Phase-oscillator array: reference counter, load/arm/run controller and N_OSC cells.
module phase_osc_array
    import onn_pkg::*;
#(
    parameter int N_OSC = ONN_N_OSC,
    parameter int PW    = ONN_PW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [0:N_OSC*PW-1] phi_in,
    input  logic                phi_valid,
    output logic                load_ready,
    input  logic                stop,
    output logic [0:N_OSC-1]    osc_out,
    output logic [PW-1:0]       phase_cnt,
    output logic                running,
    output logic                period_tick
);

    localparam logic [PW-1:0] LAST_PHASE = {PW{1'b1}};

    onn_state_e              state_q, state_d;
    logic [PW-1:0]           phase_cnt_q;
    logic                    pending_q, pending_d;
    logic [0:N_OSC*PW-1]     shadow_q, shadow_d;
    logic                    wrap;
    logic                    accept;
    logic                    apply;

    assign wrap   = (phase_cnt_q == LAST_PHASE);
    assign accept = phi_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept) state_d = ST_ARMED;
                ST_ARMED: if (wrap)   state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        load_ready = 1'b0;
        running    = 1'b0;
        apply      = 1'b0;
        case (state_q)
            ST_IDLE:  load_ready = 1'b1;
            ST_ARMED: apply = wrap;
            ST_RUN: begin
                running    = 1'b1;
                load_ready = !pending_q;
                apply      = pending_q && wrap;
            end
            default: ;
        endcase
        if (stop) apply = 1'b0;
        period_tick = running && wrap;
    end

    // A load accepted on the wrap cycle only sets pending, so it lands one full period later.
    always_comb begin
        pending_d = pending_q;
        shadow_d  = shadow_q;
        if (stop) begin
            pending_d = 1'b0;
            shadow_d  = '0;
        end else begin
            if (accept) shadow_d = phi_in;
            if (state_q == ST_RUN) begin
                if (accept)     pending_d = 1'b1;
                else if (apply) pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_cnt_q <= '0;
            pending_q   <= 1'b0;
            shadow_q    <= '0;
        end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
            pending_q   <= pending_d;
            shadow_q    <= shadow_d;
        end
    end

    assign phase_cnt = phase_cnt_q;

    for (genvar k = 0; k < N_OSC; k++) begin : g_cell
        onn_osc_cell #(
            .PW(PW)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .apply_i     (apply),
            .phase_i     (shadow_q[PW*k +: PW]),
            .phase_cnt_i (phase_cnt_q),
            .en_i        (running),
            .osc_o       (osc_out[k])
        );
    end

endmodule

// File: doc/phase_osc_array.md
PHASE_OSC_ARRAY -- requirements
Module: phase_osc_array

Interface
REQ-001 The block SHALL have parameter N_OSC, default 15, giving the number of oscillators (5x3 phase matrix).
REQ-002 The block SHALL have parameter PW, default 4, giving the phase width in bits; the period is 2^PW = 16 cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port phi_in, input, [0:N_OSC*PW-1]: packed phase vector; oscillator k occupies bits [PW*k : PW*k+PW-1], with bit PW*k as MSB.
REQ-006 The block SHALL have port phi_valid, input, 1 bit: phi_in is valid this cycle.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts phi_in this cycle; transfer occurs when phi_valid && load_ready.
REQ-008 The block SHALL have port stop, input, 1 bit: single-cycle request to halt the oscillators.
REQ-009 The block SHALL have port osc_out, output, [0:N_OSC-1]: per-oscillator square waves.
REQ-010 The block SHALL have port phase_cnt, output, [PW-1:0]: the free-running reference phase counter.
REQ-011 The block SHALL have port running, output, 1 bit: high while in state RUN.
REQ-012 The block SHALL have port period_tick, output, 1 bit: single-cycle pulse in RUN when phase_cnt == 15.

Function
REQ-013 phase_cnt SHALL increment by 1 every cycle out of reset, wrapping 15 -> 0, independent of state.
REQ-014 The FSM SHALL have exactly three states: IDLE, ARMED and RUN.
REQ-015 In IDLE, load_ready SHALL be 1; an accepted load SHALL capture phi_in into a shadow register and move the FSM to ARMED.
REQ-016 In ARMED, load_ready SHALL be 0; in the cycle phase_cnt == 15, the shadow SHALL be copied to the active phase register and the FSM SHALL move to RUN, so the first RUN cycle has phase_cnt == 0.
REQ-017 In RUN, load_ready SHALL equal !pending; an accepted load SHALL write the shadow and set pending.
REQ-018 When pending is set and phase_cnt == 15, the shadow SHALL be copied to active and pending cleared; the new phases therefore apply from phase_cnt == 0 and no mid-period glitch occurs.
REQ-019 In RUN, osc_out[k] SHALL be 1 iff ((phase_cnt - active[k]) mod 16) < 8, combinationally from registered state; in IDLE and ARMED, osc_out SHALL be all 0.
REQ-020 The phase subtraction SHALL be a PW-bit unsigned wrap-around; no sign extension is applied.
REQ-021 stop SHALL force IDLE on the next edge from any state, clear pending, and discard the shadow contents.
REQ-022 stop SHALL have priority over a same-cycle accepted load: the handshake counts as completed, the data is dropped, and the FSM enters IDLE.
REQ-023 A load accepted in RUN in the same cycle as phase_cnt == 15 with pending clear SHALL apply at the following wrap, 16 cycles later, not immediately.
REQ-024 period_tick SHALL be 0 outside RUN.

Reset
REQ-025 On a rst_n == 0 clock edge, the block SHALL reset the FSM to IDLE, phase_cnt to 0, the active and shadow registers to 0, and pending to 0.
REQ-026 Outputs in the cycle after reset SHALL be: load_ready = 1, osc_out = 0, running = 0, period_tick = 0, phase_cnt = 0.
REQ-027 Reset asserted mid-RUN SHALL abandon any pending load, with no output activity until a new load completes the ARMED sequence.

Structure
REQ-028 N_OSC, PW, the period constant (16), the half-period constant (8) and the FSM state encoding SHALL live in the shared ONN package used by control_to_neuron.
REQ-029 A per-oscillator sub-module, onn_osc_cell (phase register plus comparator), SHALL be instantiated N_OSC times through a generate loop; the FSM and phase_cnt SHALL remain in the top module.

Verification
REQ-030 Reset, then load all phases = 0 at phase_cnt == 3 -> ARMED for cycles 4..15, RUN from phase_cnt == 0, every osc_out high for counts 0..7 and low for 8..15.
REQ-031 Load oscillator 0 = 4'h4, oscillator 14 = 4'hC, others 0 -> osc_out[0] rises at phase_cnt == 4, osc_out[14] rises at phase_cnt == 12 (wrap case, high through count 3).
REQ-032 In RUN, load a new vector at phase_cnt == 6 -> load_ready drops until the wrap, old waveform persists through count 15, new phases apply at count 0, and a second phi_valid during pending is not accepted.
REQ-033 stop and an accepted load in the same cycle -> next cycle IDLE, osc_out = 0, load_ready = 1, shadow not applied.
REQ-034 Assert rst_n = 0 for one cycle mid-RUN with pending set -> all outputs at reset values, and no phase application at the next wrap.
REQ-035 Across 10 periods in RUN -> exactly one period_tick per 16 cycles, each coincident with phase_cnt == 15.
